// File: rtl/ws_array_sequencer.sv
// Sequencer for a weight-stationary SIZE x SIZE systolic array: loads a weight tile,
// streams row-skewed input vectors and deskews the column accumulators into aligned result rows.
module ws_array_sequencer #(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int SIZE      = 4,
  parameter int ARRAY_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [7:0]                num_vec,
  output logic                      busy,
  output logic                      done,
  input  logic [SIZE*BIT_WIDTH-1:0] wt_data,
  input  logic                      wt_valid,
  output logic                      wt_ready,
  input  logic [SIZE*BIT_WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      arr_control,
  output logic [SIZE*BIT_WIDTH-1:0] arr_wt,
  output logic [SIZE*BIT_WIDTH-1:0] arr_data,
  input  logic [SIZE*ACC_WIDTH-1:0] arr_acc,
  output logic [SIZE*ACC_WIDTH-1:0] res_data,
  output logic                      res_valid
);

  localparam int TAG_LEN = ARRAY_LAT + SIZE;
  localparam int WCW     = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WT,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [WCW-1:0]     wt_cnt;
  logic [7:0]         vec_left;
  logic [TAG_LEN-1:0] tag_q;
  logic               wt_fire, in_fire;

  assign wt_fire   = wt_valid && wt_ready;
  assign in_fire   = in_valid && in_ready;
  assign res_valid = tag_q[TAG_LEN-1];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    wt_ready  = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD_WT;
      end
      LOAD_WT: begin
        busy     = 1'b1;
        wt_ready = 1'b1;
        if (wt_valid && (wt_cnt == WCW'(SIZE - 1)))
          state_nxt = (vec_left == 8'd0) ? DRAIN : STREAM;
      end
      STREAM: begin
        busy     = 1'b1;
        in_ready = (vec_left != 8'd0);
        if (in_valid && (vec_left == 8'd1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // The last result leaves the tag line this cycle when only the output stage is set.
        if (tag_q[TAG_LEN-2:0] == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state       <= IDLE;
      wt_cnt      <= '0;
      vec_left    <= '0;
      arr_control <= 1'b0;
      arr_wt      <= '0;
      tag_q       <= '0;
    end else begin
      state       <= state_nxt;
      arr_control <= wt_fire;
      if (wt_fire) arr_wt <= wt_data;
      tag_q <= {tag_q[TAG_LEN-2:0], in_fire};
      if ((state == IDLE) && start) begin
        vec_left <= num_vec;
        wt_cnt   <= '0;
      end else begin
        if (wt_fire) wt_cnt <= wt_cnt + WCW'(1);
        if (in_fire) vec_left <= vec_left - 8'd1;
      end
    end
  end

  // Input skew: lane i sits behind i+1 registers so it reaches the array i cycles after lane 0.
  logic [BIT_WIDTH-1:0] lane_out [SIZE];

  for (genvar i = 0; i < SIZE; i++) begin : g_skew
    logic [BIT_WIDTH-1:0] pipe [i+1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k <= i; k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= in_fire ? in_data[i*BIT_WIDTH +: BIT_WIDTH] : '0;
        for (int k = 1; k <= i; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign lane_out[i] = pipe[i];
  end

  always_comb begin
    arr_data = '0;
    for (int i = 0; i < SIZE; i++) arr_data[i*BIT_WIDTH +: BIT_WIDTH] = lane_out[i];
  end

  // Output deskew: column j emerges j cycles after column 0, so it waits SIZE-1-j cycles.
  logic [ACC_WIDTH-1:0] col_aligned [SIZE];

  for (genvar j = 0; j < SIZE; j++) begin : g_deskew
    localparam int DEPTH = SIZE - 1 - j;
    if (DEPTH == 0) begin : g_direct
      assign col_aligned[j] = arr_acc[j*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_delay
      logic [ACC_WIDTH-1:0] pipe [DEPTH];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < DEPTH; k++) pipe[k] <= '0;
        end else begin
          pipe[0] <= arr_acc[j*ACC_WIDTH +: ACC_WIDTH];
          for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
        end
      end
      assign col_aligned[j] = pipe[DEPTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data <= '0;
    end else if (tag_q[TAG_LEN-2]) begin
      for (int j = 0; j < SIZE; j++) res_data[j*ACC_WIDTH +: ACC_WIDTH] <= col_aligned[j];
    end
  end

endmodule
